demux1to4_stream: RTL

Registered 1-to-4 stream demultiplexer: the inverse of the team's 4-to-1 mux blocks. One input stream carries a 2-bit destination select with each word; the word is captured into the holding slot of the selected output and presented there under a valid/ready handshake. It sits downstream of any single-source producer that must fan out to four consumers, and its outputs can feed the mux blocks directly for loop-back testing.

---
 rtl/demux_pkg.sv | 8 +
 rtl/demux_slot.sv | 48 ++++
 rtl/demux1to4_stream.sv | 46 ++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared constants and slot state type for the 1-to-4 stream demultiplexer.
package demux_pkg;
  localparam int N_OUT = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;
endpackage

// File: rtl/demux_slot.sv
// One output channel: single-entry holding slot with valid/ready drain.
// Delivery counter present only when DEMUX_CNT_EN is defined.
module demux_slot
  import demux_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          drain_ready,
  output logic          valid,
  output logic [DW-1:0] data
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  slot_state_t state;
  logic        drain;

  assign valid = (state == FULL);
  assign drain = valid && drain_ready;

  // load is only raised when the slot is empty or draining this cycle,
  // so it always wins over drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      data  <= '0;
    end else if (load) begin
      state <= FULL;
      data  <= load_data;
    end else if (drain) begin
      state <= EMPTY;
    end
  end

`ifdef DEMUX_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)        cnt <= '0;
    else if (drain) cnt <= cnt + 1'b1;
  end
`endif

endmodule

// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream demux: each word is steered by in_sel into that
// channel's slot. Optional per-channel delivery counters via DEMUX_CNT_EN.
module demux1to4_stream
  import demux_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*DW-1:0]    out_data
`ifdef DEMUX_CNT_EN
  ,
  output logic [N_OUT*CNT_W-1:0] out_cnt
`endif
);

  logic [N_OUT-1:0] load;

  // A full slot that drains this cycle can take the next word immediately.
  assign in_ready = !out_valid[in_sel] || out_ready[in_sel];

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    assign load[k] = in_valid && in_ready && (in_sel == SEL_W'(k));

    demux_slot #(.DW(DW)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .load        (load[k]),
      .load_data   (in_data),
      .drain_ready (out_ready[k]),
      .valid       (out_valid[k]),
      .data        (out_data[k*DW +: DW])
`ifdef DEMUX_CNT_EN
      ,
      .cnt         (out_cnt[k*CNT_W +: CNT_W])
`endif
    );
  end

endmodule
